weight_rom_server: RTL and testbench

//  Responder side of the layer-to-weight-ROM interface: a layer drives a word

---
 rtl/weight_rom_server_if.sv | 25 ++
 rtl/weight_rom_server.sv | 117 +++++++++++
 tb/tb_weight_rom_server.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/weight_rom_server_if.sv
// Layer/weight-ROM bus: layer request, assembled row response and the narrow memory port.
// slave = the row server, master = layer plus memory model.
interface weight_rom_server_if #(
  parameter int BIT    = 16,
  parameter int LANES  = 128,
  parameter int ADDR_W = 11,
  parameter int MEM_W  = 64
);
  localparam int ROW_W = LANES * BIT;
  localparam int BEATS = ROW_W / MEM_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                   ena;
  logic [ADDR_W-1:0]      addr_from_layer;
  logic [ROW_W-1:0]       data_to_layer;
  logic                   busy;
  logic                   mem_rd;
  logic [ADDR_W+BW-1:0]   mem_addr;
  logic [MEM_W-1:0]       mem_data;

  modport slave  (input  ena, addr_from_layer, mem_data,
                  output data_to_layer, busy, mem_rd, mem_addr);
  modport master (output ena, addr_from_layer, mem_data,
                  input  data_to_layer, busy, mem_rd, mem_addr);
endinterface

// File: rtl/weight_rom_server.sv
// Serves layer row requests by reading BEATS narrow memory words and assembling one wide row.
// Drives zero while a row is in flight so polling layers see "not ready".
module weight_rom_server #(
  parameter int BIT     = 16,
  parameter int LANES   = 128,
  parameter int ADDR_W  = 11,
  parameter int MEM_W   = 64,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                iRst,
  weight_rom_server_if.slave  bus
);
  localparam int ROW_W = LANES * BIT;
  localparam int BEATS = ROW_W / MEM_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, VALID} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    held_q, held_d;
  logic                 flag_q, flag_d;
  logic [BW-1:0]        issue_cnt_q, issue_cnt_d;
  logic [BW-1:0]        ret_cnt_q, ret_cnt_d;
  logic [MEM_LAT-1:0]   tag_q, tag_d;
  logic [MEM_LAT:0]     tag_sh;
  logic [ROW_W-1:0]     asm_q, asm_d;
  logic                 rd, start, drop, new_addr;

  assign rd                 = (state_q == ISSUE);
  assign bus.mem_rd         = rd;
  assign bus.mem_addr       = rd ? {held_q, issue_cnt_q} : '0;
  assign bus.busy           = (state_q == ISSUE) || (state_q == COLLECT);
  assign bus.data_to_layer  = (state_q == VALID) ? asm_q : '0;

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    flag_d      = flag_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    asm_d       = asm_q;
    tag_sh      = {tag_q, rd};
    tag_d       = tag_sh[MEM_LAT-1:0];
    start       = 1'b0;
    drop        = 1'b0;
    new_addr    = 1'b0;

    // Address is only looked at while the layer owns the bus, so X/Z when idle is harmless.
    if (bus.ena) new_addr = !flag_q || (bus.addr_from_layer != held_q);

    if (tag_q[MEM_LAT-1]) begin
      asm_d[ret_cnt_q*MEM_W +: MEM_W] = bus.mem_data;
      ret_cnt_d = ret_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE:    start = new_addr;
      ISSUE: begin
        if (!bus.ena)     drop  = 1'b1;
        else if (new_addr) start = 1'b1;
        else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST) state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (!bus.ena)     drop  = 1'b1;
        else if (new_addr) start = 1'b1;
        else if (tag_q[MEM_LAT-1] && ret_cnt_q == LAST) state_d = VALID;
      end
      VALID: begin
        if (!bus.ena)     drop  = 1'b1;
        else if (new_addr) start = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Restart and abort both flush the tag pipe so in-flight beats of the old row are dropped.
    if (start) begin
      state_d     = ISSUE;
      held_d      = bus.addr_from_layer;
      flag_d      = 1'b1;
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
      asm_d       = '0;
      tag_d       = '0;
    end
    if (drop) begin
      state_d = IDLE;
      flag_d  = 1'b0;
      tag_d   = '0;
      asm_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state_q     <= IDLE;
      held_q      <= '0;
      flag_q      <= 1'b0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      tag_q       <= '0;
      asm_q       <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      flag_q      <= flag_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      tag_q       <= tag_d;
      asm_q       <= asm_d;
    end
  end
endmodule

// File: tb/tb_weight_rom_server.sv
// Directed bench for weight_rom_server with a 2-cycle narrow memory model and golden row builder.
module tb_weight_rom_server;
  localparam int ROW_W = 2048;
  localparam int MEM_W = 64;

  logic clk = 1'b0;
  logic iRst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  weight_rom_server_if #(.BIT(16), .LANES(128), .ADDR_W(11), .MEM_W(64)) bus ();

  weight_rom_server #(.BIT(16), .LANES(128), .ADDR_W(11), .MEM_W(64), .MEM_LAT(2)) dut (
    .clk  (clk),
    .iRst (iRst),
    .bus  (bus)
  );

  function automatic logic [63:0] word(input logic [10:0] r, input logic [4:0] b);
    logic [15:0] bb;
    bb = {11'd0, b};
    return {5'd0, r, 16'hA5A5 ^ bb, bb + 16'd1, b, r};
  endfunction

  function automatic logic [ROW_W-1:0] golden(input logic [10:0] r);
    logic [ROW_W-1:0] row;
    row = '0;
    for (int b = 0; b < 32; b++) row[b*MEM_W +: MEM_W] = word(r, 5'(b));
    return row;
  endfunction

  logic [63:0] p0 = '0, p1 = '0;
  always @(posedge clk) begin
    p0 <= bus.mem_rd ? word(bus.mem_addr[15:5], bus.mem_addr[4:0]) : 64'd0;
    p1 <= p0;
  end
  assign bus.mem_data = p1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    int bi;
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      bi = 0;
      for (int b = 31; b >= 0; b--) if (obs[b*MEM_W +: MEM_W] !== exp[b*MEM_W +: MEM_W]) bi = b;
      $error("FAIL %s: beat %0d observed=%h expected=%h", tag, bi,
             obs[bi*MEM_W +: MEM_W], exp[bi*MEM_W +: MEM_W]);
    end
  endtask

  // Request a row and poll like a layer: checks issue sequence, latency and the delivered row.
  task automatic fetch(input string tag, input logic [10:0] a);
    int lat, rds;
    logic aok;
    lat = 0; rds = 0; aok = 1'b1;
    bus.ena = 1'b1;
    bus.addr_from_layer = a;
    while (lat < 200) begin
      tick();
      lat++;
      if (bus.mem_rd) begin
        if (bus.mem_addr !== {a, 5'(rds)}) aok = 1'b0;
        rds++;
      end
      if (bus.data_to_layer !== '0) break;
    end
    chk({tag, "_latency"}, lat, 35);
    chk({tag, "_reads"}, rds, 32);
    chk({tag, "_addrseq"}, aok, 1);
    chk({tag, "_row"}, bus.data_to_layer, golden(a));
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [ROW_W-1:0] snap;
    logic rd_seen, moved;
    logic [10:0] poll [4];

    iRst = 1'b1;
    bus.ena = 1'b0;
    bus.addr_from_layer = '0;
    repeat (3) tick();
    chk("rst_data", bus.data_to_layer, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    iRst = 1'b0;

    // Reset in the middle of an issue burst, then same address again
    bus.ena = 1'b1;
    bus.addr_from_layer = 11'h123;
    repeat (10) tick();
    chk("mid_issue_rd", bus.mem_rd, 1);
    iRst = 1'b1;
    #1;
    chk("async_rst_rd", bus.mem_rd, 0);
    chk("async_rst_data", bus.data_to_layer, 0);
    chk("async_rst_busy", bus.busy, 0);
    tick();
    iRst = 1'b0;
    fetch("refetch_after_rst", 11'h123);

    fetch("row_400", 11'h400);

    // Held address in VALID: no refetch, stable output
    fetch("row_005", 11'h005);
    snap = bus.data_to_layer;
    rd_seen = 1'b0; moved = 1'b0;
    repeat (100) begin
      tick();
      if (bus.mem_rd) rd_seen = 1'b1;
      if (bus.data_to_layer !== snap) moved = 1'b1;
    end
    chk("hold_no_rd", rd_seen, 0);
    chk("hold_stable", moved, 0);
    fetch("row_006", 11'h006);

    // Address changes at issue beat 31 and at collect beat 1
    bus.addr_from_layer = 11'h010;
    repeat (32) tick();
    chk("beat31_addr", bus.mem_addr, {11'h010, 5'd31});
    bus.addr_from_layer = 11'h011;
    repeat (34) tick();
    chk("collect_rd", bus.mem_rd, 0);
    chk("collect_busy", bus.busy, 1);
    bus.addr_from_layer = 11'h010;
    tick();
    chk("restart_zero", bus.data_to_layer, 0);
    fetch("row_011", 11'h011);
    chk("lane0_011", bus.data_to_layer[15:0], 16'h0011);
    chk("lane127_011", bus.data_to_layer[ROW_W-1 -: 16], 16'h0011);

    // ena drops mid-fetch, then returns with the same address
    bus.addr_from_layer = 11'h020;
    repeat (23) tick();
    bus.ena = 1'b0;
    bus.addr_from_layer = 'x;
    tick();
    chk("ena_low_data", bus.data_to_layer, 0);
    chk("ena_low_busy", bus.busy, 0);
    repeat (5) tick();
    chk("ena_low_rd", bus.mem_rd, 0);
    chk("ena_low_data2", bus.data_to_layer, 0);
    fetch("row_020_again", 11'h020);

    // FC1-style poll: bias row then descending weight rows
    poll[0] = 11'h400; poll[1] = 11'h3FF; poll[2] = 11'h3FE; poll[3] = 11'h3FD;
    for (int i = 0; i < 4; i++) fetch($sformatf("poll%0d", i), poll[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
